// File: rtl/bcd_7seg_scanner_pkg.sv
// Shared types and segment patterns for the multiplexed BCD display scanner.
package bcd_display_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'b001,
    DRIVE = 3'b010,
    GAP   = 3'b100
  } scan_state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high before output polarity.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_7seg_scanner_if.sv
// Load/display bundle between a BCD producer and the display scanner.
interface bcd_7seg_scanner_if #(
  parameter int DIGITS = 3
);
  logic                  i_enable;
  logic                  i_load;
  logic [DIGITS*4-1:0]   i_bcd;
  logic [6:0]            o_seg;
  logic [DIGITS-1:0]     o_an;
  logic                  o_frame;
  logic                  o_invalid;

  modport master (
    output i_enable, i_load, i_bcd,
    input  o_seg, o_an, o_frame, o_invalid
  );

  modport slave (
    input  i_enable, i_load, i_bcd,
    output o_seg, o_an, o_frame, o_invalid
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational nibble to segment decoder; nibbles above 9 show a dash.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) begin
      case (nib_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_7seg_scanner.sv
// Time-multiplexed 7-segment scanner with frame-aligned (tear-free) updates,
// leading-zero blanking and an all-off gap between digits.
module bcd_7seg_scanner
  import bcd_display_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int REFRESH_DIV    = 1000,
  parameter int GAP_CYCLES     = 2,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  bcd_7seg_scanner_if.slave  bus
);

  localparam int DW = DIGITS * 4;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int GW = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int IW = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam logic [6:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

  scan_state_t       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DW-1:0]     disp_q, disp_d, pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              invalid_q, invalid_d;
  logic              frame_q;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic advance, wrap, entry, swap;
  logic any_bad, lz_run, blank, drive_d;
  logic [3:0] nib;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    gap_d   = gap_q;
    advance = 1'b0;
    entry   = 1'b0;
    if (!bus.i_enable) begin
      state_d = OFF;
      idx_d   = '0;
      pre_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = DRIVE;
          idx_d   = '0;
          pre_d   = '0;
          entry   = 1'b1;
        end
        DRIVE: begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = '0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) advance = 1'b1;
          else                   gap_d   = gap_q + 1'b1;
        end
        default: state_d = OFF;
      endcase
    end
    wrap = advance && (idx_q == IDX_LAST);
    if (advance) begin
      state_d = DRIVE;
      idx_d   = wrap ? '0 : idx_q + 1'b1;
    end
  end

  // A load landing on the boundary cycle is treated as pending, so it is
  // shown straight away instead of waiting a full extra frame.
  always_comb begin
    swap         = (wrap || entry) && (pend_valid_q || bus.i_load);
    pend_d       = bus.i_load ? bus.i_bcd : pend_q;
    pend_valid_d = swap ? 1'b0 : (bus.i_load || pend_valid_q);
    disp_d       = swap ? pend_d : disp_q;
    any_bad      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_d[i*4 +: 4] > 4'd9) any_bad = 1'b1;
    end
    invalid_d = swap ? any_bad : invalid_q;
  end

  always_comb begin
    nib    = '0;
    lz_run = 1'b1;
    blank  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (disp_d[i*4 +: 4] == 4'd0);
      if (idx_d == IW'(i)) begin
        nib   = disp_d[i*4 +: 4];
        blank = (BLANK_LZ != 0) && (i != 0) && lz_run;
      end
    end
    drive_d = (state_d == DRIVE) && !blank;
    an_d    = drive_d ? (DIGITS'(1) << idx_d) : '0;
  end

  bcd_to_7seg u_dec (
    .nib_i   (nib),
    .blank_i (!drive_d),
    .seg_o   (seg_d)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= OFF;
      idx_q        <= '0;
      pre_q        <= '0;
      gap_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      invalid_q    <= 1'b0;
      frame_q      <= 1'b0;
      seg_q        <= SEG_OFF ^ SEG_INV;
      an_q         <= AN_INV;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pre_q        <= pre_d;
      gap_q        <= gap_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      invalid_q    <= invalid_d;
      frame_q      <= wrap;
      seg_q        <= seg_d ^ SEG_INV;
      an_q         <= an_d ^ AN_INV;
    end
  end

  assign bus.o_seg     = seg_q;
  assign bus.o_an      = an_q;
  assign bus.o_frame   = frame_q;
  assign bus.o_invalid = invalid_q;

endmodule
